// File: rtl/my_top_level.sv
// my_top_level: unsigned adder split into LATENCY carry-pipelined slices; io_X = io_A + io_B.
// Define MYTOPLEVEL_SAT_EN to saturate to all-ones on top carry-out instead of wrapping.
module my_top_level #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_A,
    input  logic [WIDTH-1:0] io_B,
    output logic [WIDTH-1:0] io_X
);
`ifdef MYTOPLEVEL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int SW = WIDTH / LATENCY;

    for (genvar s = 0; s < LATENCY; s++) begin : g_stg
        localparam int LO   = s * SW;
        localparam bit LAST = (s == LATENCY - 1);
        localparam int CW   = SW + ((!LAST || SAT) ? 1 : 0);
        // ra_* carries finished result slices below LO and untouched A slices from LO up
        logic [WIDTH-1:0]    ra_in, ra_mrg, ra_d, ra_q;
        logic [WIDTH-LO-1:0] b_in;
        logic                c_in;
        logic [CW-1:0]       sum;
        if (s == 0) begin : g_head
            assign ra_in = io_A;
            assign b_in  = io_B;
            assign c_in  = 1'b0;
        end else begin : g_tail
            assign ra_in = g_stg[s-1].ra_q;
            assign b_in  = g_stg[s-1].g_fwd.b_q;
            assign c_in  = g_stg[s-1].g_fwd.c_q;
        end
        assign sum = CW'(ra_in[LO +: SW]) + CW'(b_in[SW-1:0]) + CW'(c_in);
        always_comb begin
            ra_mrg = ra_in;
            ra_mrg[LO +: SW] = sum[SW-1:0];
        end
        if (LAST && SAT) begin : g_sat
            assign ra_d = sum[SW] ? '1 : ra_mrg;
        end else begin : g_wrap
            assign ra_d = ra_mrg;
        end
        always_ff @(posedge clk or posedge reset) begin
            if (reset) ra_q <= '0;
            else       ra_q <= ra_d;
        end
        if (!LAST) begin : g_fwd
            logic [WIDTH-LO-SW-1:0] b_q;
            logic                   c_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    b_q <= '0;
                    c_q <= 1'b0;
                end else begin
                    b_q <= b_in[WIDTH-LO-1:SW];
                    c_q <= sum[SW];
                end
            end
        end
    end

    assign io_X = g_stg[LATENCY-1].ra_q;
endmodule

// File: tb/tb_my_top_level.sv
// tb_my_top_level: random and directed checks of 8-bit adders at LATENCY 1 and 4 against a sum-history model.
module tb_my_top_level;
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a, b, x1, x4;
    int         nvec  = 0;
    int         nerr  = 0;
    int         cnt   = 0;
    int         hist[$];
    logic [63:0] w;
    int         wbits = 0;

    always #5 clk = ~clk;

    my_top_level #(.WIDTH(8), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .io_A(a), .io_B(b), .io_X(x1)
    );
    my_top_level #(.WIDTH(8), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .io_A(a), .io_B(b), .io_X(x4)
    );

    function automatic int ref_add(input int p, input int q);
`ifdef MYTOPLEVEL_SAT_EN
        return (p + q > 255) ? 255 : p + q;
`else
        return (p + q) % 256;
`endif
    endfunction

    // cnt = clean edges since reset; a sum reaches io_X once it has seen lat clean edges
    function automatic logic [7:0] expect_x(input int lat);
        return (reset || cnt < lat) ? 8'h00 : 8'(hist[lat-1]);
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) cnt = 0;
        else begin
            cnt++;
            hist.push_front(ref_add(int'(a), int'(b)));
            if (hist.size() > 8) void'(hist.pop_back());
        end
        #1;
        check("lat1", x1, expect_x(1));
        check("lat4", x4, expect_x(4));
    endtask

    task automatic drive(input logic [7:0] p, input logic [7:0] q);
        a = p;
        b = q;
        step();
    endtask

    task automatic next_pair();
        if (wbits < 16) begin
            w = {$urandom, $urandom};
            wbits = 64;
        end
        a = w[7:0];
        b = w[15:8];
        w = w >> 16;
        wbits -= 16;
    endtask

    initial begin
        a = 8'h12;
        b = 8'h34;
        repeat (10) step();
        check("rst_hold", x1, 8'h00);
        reset = 1'b0;
        drive(8'h03, 8'h05);
        check("basic_a", x1, 8'h08);
        drive(8'h10, 8'h20);
        check("basic_b", x1, 8'h30);
        drive(8'hFF, 8'h01);
        drive(8'h80, 8'h80);
        drive(8'h0F, 8'h01);
        repeat (4) drive(8'h0F, 8'h01);
        check("carry_l4", x4, 8'h10);
        repeat (50) begin
            next_pair();
            step();
        end
        #3;
        reset = 1'b1;
        cnt = 0;
        #1;
        check("async_l1", x1, 8'h00);
        check("async_l4", x4, 8'h00);
        repeat (2) begin
            next_pair();
            step();
        end
        reset = 1'b0;
        repeat (20) begin
            next_pair();
            step();
        end
        repeat (6) drive(8'h5A, 8'h21);
        check("stable", x4, 8'h7B);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/my_top_level.md
Name: my_top_level

Overview:
- Registered unsigned adder: io_X = io_A + io_B modulo 2^WIDTH. The result appears LATENCY clock cycles after the operands are sampled.
- Internally, the adder is split into LATENCY equal-width carry-pipelined slices, so wide or fast configurations meet timing.
- Sits behind the operand-driving BFM as the arithmetic datapath under test.
- Has no handshake: every cycle samples a new operand pair.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥1 and divisible by LATENCY.
- LATENCY, 1, number of pipeline stages (cycles from operand sample to io_X). Allowed range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high reset; clears all pipeline state.
- io_A  input  WIDTH  operand A, unsigned, sampled on rising clk.
- io_B  input  WIDTH  operand B, unsigned, sampled on rising clk.
- io_X  output  WIDTH  registered result, driven directly from the final pipeline register.

Behaviour:
- One clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset:
  - reset=1 immediately (without waiting for a clock edge) forces every pipeline register, every carry register and io_X to 0.
  - While reset is held, io_X stays 0 and operands are ignored.
- Slicing: SW = WIDTH/LATENCY. Slice k covers bits [k*SW +: SW].
- Stage s (s = 0..LATENCY-1), on each rising clk with reset=0:
  - Computes slice s as operand-A slice + operand-B slice + carry from stage s-1. The carry-in for stage 0 is 0.
  - Registers the SW-bit sum and the carry-out.
  - Forwards the lower result slices already computed and the not-yet-added upper operand slices, each delayed one stage.
- Carry out of the top slice is discarded (modulo 2^WIDTH wrap), e.g. 8'hFF + 8'h01 = 8'h00.
- Latency: operands present at rising edge N appear on io_X after rising edge N+LATENCY-1 completes. With LATENCY=1, io_X is valid right after edge N.
- Throughput: one result per cycle. Back-to-back operand pairs produce back-to-back results in order, with no bubbles.
- Reset deasserted mid-stream: the pipeline restarts from all-zero state. Results flushed by reset are lost, and io_X shows 0 until the first post-reset operand pair reaches the output.
- Reset asserted mid-operation: in-flight results are discarded at once and io_X goes to 0 asynchronously.
- Stable inputs: with io_A/io_B held constant, io_X settles to the constant sum and holds it.
- No X-propagation from reset: all state has a defined reset value.
- Operands are unsigned. There is no overflow output.

Optional Feature:
- Macro: MYTOPLEVEL_SAT_EN.
- Defined: saturating add. The top slice carry-out is registered; if it is 1, io_X = all-ones (8'hFF at WIDTH=8) instead of the wrapped value. The saturation decision is made in the last stage, with the same latency as the plain add.
- Undefined: modulo-2^WIDTH wrap as described above; no extra logic.

Test Plan:
- Reset check: hold reset=1 for 10 cycles with io_A=8'h12, io_B=8'h34 → io_X=8'h00 throughout. Assert reset between clock edges → io_X goes to 0 without waiting for a clock edge.
- Basic add, LATENCY=1: after reset, drive io_A=8'h03, io_B=8'h05 at edge N → io_X=8'h08 after edge N. Next cycle drive 8'h10 + 8'h20 → io_X=8'h30.
- Wrap: io_A=8'hFF, io_B=8'h01 → io_X=8'h00. io_A=8'h80, io_B=8'h80 → io_X=8'h00. With MYTOPLEVEL_SAT_EN defined → io_X=8'hFF for both.
- Streaming: 50 consecutive random pairs, one per cycle (bytes unpacked from a wide shift word as low byte = A, next byte = B) → each io_X equals (A+B)&8'hFF, in order, LATENCY cycles later, with no gaps.
- Pipelined config, WIDTH=8, LATENCY=4: drive 8'h0F + 8'h01 (carry crosses slice boundaries) at edge N → io_X=8'h10 after edge N+3. Intermediate cycles still show earlier results.
- Reset mid-stream: while streaming with LATENCY=4, assert reset for 2 cycles → io_X=0 immediately. After deassert, io_X shows 0 until the first new pair emerges LATENCY cycles later with the correct sum.
